// File: rtl/wall_sequencer.sv
// wall_sequencer: picks the next wall, fetches its mask from the wall ROM,
// counts frames while it approaches, then pulses arrival and advances.
// Ports:
//   clk_in, rst_n_in        clock, async active-low reset
//   start_in, stop_in       begin game (IDLE only) / abort to IDLE (any state)
//   new_frame_in            one-cycle pulse per video frame
//   mask_valid_in, mask_in  ROM response
//   fetch_valid_out         one-cycle ROM request, qualifies bitmask_idx_out
//   bitmask_idx_out         ROM address (current wall index)
//   wall_mask_out           active wall mask
//   wall_valid_out          wall_mask_out holds an active wall
//   wall_depth_out          frames remaining before arrival
//   wall_arrive_out         one-cycle arrival pulse
//   walls_done_out          saturating count of arrived walls
//   fetch_err_out           sticky fetch-timeout flag
module wall_sequencer #(
    parameter int BIT_MASK_SIZE   = 3600,
    parameter int NUM_WALLS       = 10,
    parameter int FRAMES_PER_WALL = 180,
    parameter int FETCH_TIMEOUT   = 8,
    localparam int IW = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1,
    localparam int DW = (FRAMES_PER_WALL > 1) ? $clog2(FRAMES_PER_WALL) : 1
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     start_in,
    input  logic                     stop_in,
    input  logic                     new_frame_in,
    input  logic                     mask_valid_in,
    input  logic [BIT_MASK_SIZE-1:0] mask_in,
    output logic                     fetch_valid_out,
    output logic [IW-1:0]            bitmask_idx_out,
    output logic [BIT_MASK_SIZE-1:0] wall_mask_out,
    output logic                     wall_valid_out,
    output logic [DW-1:0]            wall_depth_out,
    output logic                     wall_arrive_out,
    output logic [15:0]              walls_done_out,
    output logic                     fetch_err_out
);

    localparam int TW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(FETCH_TIMEOUT - 1);
    localparam logic [DW-1:0] D_INIT = DW'(FRAMES_PER_WALL - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_WALLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_APPR,
        S_ARRIVE
    } state_t;

    state_t        state;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= S_IDLE;
            tcnt            <= '0;
            fetch_valid_out <= 1'b0;
            bitmask_idx_out <= '0;
            wall_mask_out   <= '0;
            wall_valid_out  <= 1'b0;
            wall_depth_out  <= '0;
            wall_arrive_out <= 1'b0;
            walls_done_out  <= '0;
            fetch_err_out   <= 1'b0;
        end else begin
            // Both pulses are high only in the state that owns them.
            fetch_valid_out <= 1'b0;
            wall_arrive_out <= 1'b0;
            if (stop_in) begin
                // Score and error flag are kept for readout after abort.
                state           <= S_IDLE;
                wall_valid_out  <= 1'b0;
                wall_depth_out  <= '0;
                bitmask_idx_out <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start_in) begin
                            state           <= S_FETCH;
                            fetch_valid_out <= 1'b1;
                            walls_done_out  <= '0;
                            fetch_err_out   <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        state <= S_WAIT;
                        tcnt  <= '0;
                    end
                    S_WAIT: begin
                        if (mask_valid_in) begin
                            wall_mask_out  <= mask_in;
                            wall_valid_out <= 1'b1;
                            wall_depth_out <= D_INIT;
                            state          <= S_APPR;
                        end else if (tcnt == T_LAST) begin
                            // Re-issue the same index; flag stays set.
                            fetch_err_out   <= 1'b1;
                            fetch_valid_out <= 1'b1;
                            state           <= S_FETCH;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    S_APPR: begin
                        if (new_frame_in) begin
                            if (wall_depth_out == '0) begin
                                state           <= S_ARRIVE;
                                wall_arrive_out <= 1'b1;
                                if (walls_done_out != 16'hFFFF)
                                    walls_done_out <= walls_done_out + 1'b1;
                            end else begin
                                wall_depth_out <= wall_depth_out - 1'b1;
                            end
                        end
                    end
                    S_ARRIVE: begin
                        bitmask_idx_out <= (bitmask_idx_out == I_LAST) ?
                                           '0 : bitmask_idx_out + 1'b1;
                        fetch_valid_out <= 1'b1;
                        state           <= S_FETCH;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
